fifo_wr_arbiter: RTL and testbench

// - Shares the single TX-FIFO write port (REF_CLK domain) between NUM_REQ byte/word producers,
//   e.g. the register-file read response and the 16-bit ALU result.
// - Round-robin grant; latches the granted payload; serialises 1- or 2-byte frames
//   (low byte first) into the FIFO, honouring FIFO_FULL back-pressure.
// - Sits between the system controller datapath and FIFO_TOP's write side.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_grant.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the TX-FIFO write-port arbiter.
//   arb_state_e  - arbiter FSM state encoding
//   ARB_NUM_REQ  - default requester count
//   ARB_IDX_W    - grant index width for the default requester count
//   arb_idx_w()  - grant index width for any requester count (minimum 1)
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SEND_LO = 2'd1,
      ARB_SEND_HI = 2'd2
   } arb_state_e;

   localparam int ARB_NUM_REQ = 2;
   localparam int ARB_IDX_W   = $clog2(ARB_NUM_REQ);

   // A single requester still needs a 1-bit index so port widths stay legal.
   function automatic int arb_idx_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
// Combinational round-robin grant: picks the first set request bit searching
// from ptr upward, wrapping at NUM_REQ.
//   req      in   NUM_REQ  request vector
//   ptr      in   IDX_W    highest-priority requester index
//   gnt      out  NUM_REQ  one-hot grant (all zero when no request)
//   idx      out  IDX_W    binary index of the granted requester
//   any_req  out  1        at least one request bit set
// ---------------------------------------------------------------------------
module rr_grant
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = ARB_NUM_REQ,
   parameter int IDX_W   = ARB_IDX_W
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any_req
);

   logic found;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the loops can leave it unassigned and infer a latch.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      found   = 1'b0;
      any_req = |req;
      // Offset 0 is the current priority holder; later offsets wrap around.
      for (int off = 0; off < NUM_REQ; off++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               idx    = IDX_W'(i);
            end
         end
      end
   end

endmodule : rr_grant

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the TX-FIFO write port between NUM_REQ producers. A round-robin grant
// latches one requester's payload, then serialises 1 or 2 bytes (low byte
// first) into the FIFO, stalling while FIFO_FULL is high.
//   CLK           in   1                     clock
//   RST           in   1                     async, active-high reset
//   REQ_VLD       in   NUM_REQ               request, held until its REQ_ACK
//   REQ_TWO_BYTE  in   NUM_REQ               1 = two bytes, 0 = low byte only
//   REQ_DATA      in   NUM_REQ*2*DATA_WIDTH  requester i at [i*2W +: 2W]
//   REQ_ACK       out  NUM_REQ               pulse with the frame's last write
//   FIFO_FULL     in   1                     FIFO full flag
//   FIFO_WR_INC   out  1                     FIFO write strobe
//   FIFO_P_DATA   out  DATA_WIDTH            FIFO write data
//   BUSY          out  1                     a frame is in progress
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = ARB_NUM_REQ,
   parameter int DATA_WIDTH = 8
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [NUM_REQ-1:0]             REQ_VLD,
   input  logic [NUM_REQ-1:0]             REQ_TWO_BYTE,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]             REQ_ACK,
   input  logic                           FIFO_FULL,
   output logic                           FIFO_WR_INC,
   output logic [DATA_WIDTH-1:0]          FIFO_P_DATA,
   output logic                           BUSY
);

   localparam int IDX_W = arb_idx_w(NUM_REQ);
   localparam int PW    = 2 * DATA_WIDTH;

   arb_state_e          state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [PW-1:0]       lat_data;
   logic                lat_two;
   logic [IDX_W-1:0]    lat_idx;

   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic                any_req;
   logic [PW-1:0]       sel_data;
   logic [IDX_W-1:0]    next_ptr;
   logic                last_wr;

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_grant (
      .req     (REQ_VLD),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .idx     (gnt_idx),
      .any_req (any_req)
   );

   // One-hot grant, so OR-ing the masked payload slices selects exactly one.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) sel_data = sel_data | REQ_DATA[i*PW +: PW];
      end
   end

   // The requester just served drops to lowest priority.
   assign next_ptr = (lat_idx == IDX_W'(NUM_REQ - 1)) ? '0 : lat_idx + IDX_W'(1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         lat_data <= '0;
         lat_two  <= 1'b0;
         lat_idx  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  lat_data <= sel_data;
                  lat_two  <= |(REQ_TWO_BYTE & gnt);
                  lat_idx  <= gnt_idx;
                  state    <= ARB_SEND_LO;
               end
            end
            ARB_SEND_LO: begin
               if (!FIFO_FULL) begin
                  if (lat_two) begin
                     state <= ARB_SEND_HI;
                  end else begin
                     rr_ptr <= next_ptr;
                     state  <= ARB_IDLE;
                  end
               end
            end
            ARB_SEND_HI: begin
               if (!FIFO_FULL) begin
                  rr_ptr <= next_ptr;
                  state  <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Write-side outputs decode straight from state so a full FIFO blocks the
   // strobe in the same cycle it rises.
   assign FIFO_WR_INC = (state != ARB_IDLE) && !FIFO_FULL;
   assign BUSY        = (state != ARB_IDLE);
   assign last_wr     = FIFO_WR_INC && ((state == ARB_SEND_HI) || !lat_two);

   always_comb begin
      case (state)
         ARB_SEND_LO: FIFO_P_DATA = lat_data[DATA_WIDTH-1:0];
         ARB_SEND_HI: FIFO_P_DATA = lat_data[PW-1:DATA_WIDTH];
         default:     FIFO_P_DATA = '0;
      endcase
   end

   always_comb begin
      REQ_ACK = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         REQ_ACK[i] = last_wr && (lat_idx == IDX_W'(i));
      end
   end

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter with two requesters and 8-bit bytes.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  REQ_VLD;
   logic [1:0]  REQ_TWO_BYTE;
   logic [31:0] REQ_DATA;
   logic [1:0]  REQ_ACK;
   logic        FIFO_FULL;
   logic        FIFO_WR_INC;
   logic [7:0]  FIFO_P_DATA;
   logic        BUSY;

   int n_checks = 0;
   int n_pass   = 0;
   int ack0_cnt = 0;
   int ack1_cnt = 0;

   always #5 CLK = ~CLK;

   fifo_wr_arbiter #(
      .NUM_REQ    (2),
      .DATA_WIDTH (8)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .REQ_VLD      (REQ_VLD),
      .REQ_TWO_BYTE (REQ_TWO_BYTE),
      .REQ_DATA     (REQ_DATA),
      .REQ_ACK      (REQ_ACK),
      .FIFO_FULL    (FIFO_FULL),
      .FIFO_WR_INC  (FIFO_WR_INC),
      .FIFO_P_DATA  (FIFO_P_DATA),
      .BUSY         (BUSY)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic outs(input string tag, input logic wr, input logic [7:0] pd,
                       input logic [1:0] ack, input logic busy);
      #1;
      check({tag, ".wr"},   {31'd0, FIFO_WR_INC}, {31'd0, wr});
      check({tag, ".data"}, {24'd0, FIFO_P_DATA}, {24'd0, pd});
      check({tag, ".ack"},  {30'd0, REQ_ACK},     {30'd0, ack});
      check({tag, ".busy"}, {31'd0, BUSY},        {31'd0, busy});
   endtask

   initial begin
      RST          = 1'b1;
      REQ_VLD      = 2'b00;
      REQ_TWO_BYTE = 2'b00;
      REQ_DATA     = 32'h0;
      FIFO_FULL    = 1'b0;
      outs("reset", 1'b0, 8'h00, 2'b00, 1'b0);
      tick();
      tick();
      RST = 1'b0;
      outs("post_reset", 1'b0, 8'h00, 2'b00, 1'b0);

      // Single 1-byte request from requester 0.
      REQ_VLD      = 2'b01;
      REQ_TWO_BYTE = 2'b00;
      REQ_DATA     = 32'h0000_00A5;
      tick();
      outs("one_byte", 1'b1, 8'hA5, 2'b01, 1'b1);
      REQ_VLD = 2'b00;
      tick();
      outs("one_byte_idle", 1'b0, 8'h00, 2'b00, 1'b0);

      // Two-byte frame from requester 1 (rr_ptr now 1).
      REQ_VLD      = 2'b10;
      REQ_TWO_BYTE = 2'b10;
      REQ_DATA     = 32'h1234_0000;
      tick();
      outs("two_byte_lo", 1'b1, 8'h34, 2'b00, 1'b1);
      tick();
      outs("two_byte_hi", 1'b1, 8'h12, 2'b10, 1'b1);
      REQ_VLD = 2'b00;
      tick();
      outs("two_byte_idle", 1'b0, 8'h00, 2'b00, 1'b0);

      // Contention: both held for four 1-byte frames, rr_ptr back at 0.
      REQ_VLD      = 2'b11;
      REQ_TWO_BYTE = 2'b00;
      REQ_DATA     = 32'h0022_0011;
      for (int f = 0; f < 4; f++) begin
         tick();
         #1;
         if (REQ_ACK[0]) ack0_cnt++;
         if (REQ_ACK[1]) ack1_cnt++;
         check($sformatf("rr_frame%0d.ack", f), {30'd0, REQ_ACK},
               (f % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("rr_frame%0d.data", f), {24'd0, FIFO_P_DATA},
               (f % 2 == 0) ? 32'h11 : 32'h22);
         if (f == 3) REQ_VLD = 2'b00;
         tick();
         check($sformatf("rr_gap%0d.busy", f), {31'd0, BUSY}, 32'd0);
      end
      check("rr_ack0_count", ack0_cnt, 32'd2);
      check("rr_ack1_count", ack1_cnt, 32'd2);

      // Back-pressure for 5 cycles in SEND_HI (rr_ptr 0, requester 0).
      REQ_VLD      = 2'b01;
      REQ_TWO_BYTE = 2'b01;
      REQ_DATA     = 32'h0000_1234;
      tick();
      outs("bp_lo", 1'b1, 8'h34, 2'b00, 1'b1);
      tick();
      FIFO_FULL = 1'b1;
      outs("bp_full0", 1'b0, 8'h12, 2'b00, 1'b1);
      for (int c = 1; c < 5; c++) begin
         tick();
         outs($sformatf("bp_full%0d", c), 1'b0, 8'h12, 2'b00, 1'b1);
      end
      tick();
      FIFO_FULL = 1'b0;
      outs("bp_release", 1'b1, 8'h12, 2'b01, 1'b1);
      REQ_VLD = 2'b00;
      tick();
      outs("bp_idle", 1'b0, 8'h00, 2'b00, 1'b0);

      // Reset in SEND_HI of a requester-1 frame (rr_ptr 1).
      REQ_VLD      = 2'b10;
      REQ_TWO_BYTE = 2'b10;
      REQ_DATA     = 32'hABCD_0000;
      tick();
      outs("rst_lo", 1'b1, 8'hCD, 2'b00, 1'b1);
      tick();
      outs("rst_hi", 1'b1, 8'hAB, 2'b10, 1'b1);
      RST = 1'b1;
      outs("rst_async", 1'b0, 8'h00, 2'b00, 1'b0);
      REQ_VLD = 2'b00;
      tick();
      RST = 1'b0;
      outs("rst_release", 1'b0, 8'h00, 2'b00, 1'b0);
      // rr_ptr must be 0 again: with both requesting, requester 0 wins.
      REQ_VLD      = 2'b11;
      REQ_TWO_BYTE = 2'b00;
      REQ_DATA     = 32'h0066_0055;
      tick();
      outs("rst_ptr", 1'b1, 8'h55, 2'b01, 1'b1);
      REQ_VLD = 2'b00;
      tick();
      outs("rst_ptr_idle", 1'b0, 8'h00, 2'b00, 1'b0);

      // Payload changes after grant must not reach the FIFO.
      REQ_VLD      = 2'b01;
      REQ_TWO_BYTE = 2'b01;
      REQ_DATA     = 32'h0000_BEEF;
      tick();
      REQ_DATA     = 32'h5A5A_0000;
      REQ_TWO_BYTE = 2'b00;
      outs("stable_lo", 1'b1, 8'hEF, 2'b00, 1'b1);
      tick();
      outs("stable_hi", 1'b1, 8'hBE, 2'b01, 1'b1);
      REQ_VLD = 2'b00;
      tick();
      outs("stable_idle", 1'b0, 8'h00, 2'b00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fifo_wr_arbiter
